// File: rtl/async_receiver.sv
// async_receiver: oversampling UART receiver (8N1), byte strobe plus framing-error strobe.
// Optional line-idle / end-of-packet detection when ASYNC_RECEIVER_IDLE_DETECT_EN is defined.
module async_receiver #(
    parameter int ClkFrequency          = 20000000,
    parameter int Baud                  = 38400,
    parameter int Oversampling          = 8,
    parameter int BaudGeneratorAccWidth = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_frame_error
`ifdef ASYNC_RECEIVER_IDLE_DETECT_EN
    ,
    output logic       RxD_idle,
    output logic       RxD_endofpacket
`endif
);

    localparam int W   = BaudGeneratorAccWidth;
    localparam int OsW = $clog2(Oversampling);

    // Fractional increment, rounded; the carry out of the low W bits is the tick.
    localparam longint IncL = ((longint'(Baud) * Oversampling << (W - 4)) + (ClkFrequency >> 5))
                              / (ClkFrequency >> 4);
    localparam logic [W:0] Inc = IncL[W:0];

    localparam logic [OsW-1:0] PhaseLast = OsW'(Oversampling - 1);
    localparam logic [OsW-1:0] PhaseHalf = OsW'(Oversampling / 2);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] START     = 4'd1;
    localparam logic [3:0] BIT0      = 4'd2;
    localparam logic [3:0] BIT7      = 4'd9;
    localparam logic [3:0] STOP      = 4'd10;
    localparam logic [3:0] WAIT_HIGH = 4'd11;

    logic [W:0]     acc;
    logic           tick;
    logic           rxSync1, rxSync2;
    logic [1:0]     filtCnt;
    logic           rxBit;
    logic [OsW-1:0] phase;
    logic           sample;
    logic [3:0]     state;
    logic [7:0]     shiftReg;

    always_ff @(posedge clk) begin
        if (reset) acc <= '0;
        else       acc <= {1'b0, acc[W-1:0]} + Inc;
    end

    assign tick = acc[W];

    always_ff @(posedge clk) begin
        if (reset) begin
            rxSync1 <= 1'b1;
            rxSync2 <= 1'b1;
            filtCnt <= 2'd3;
            rxBit   <= 1'b1;
        end else begin
            rxSync1 <= RxD;
            rxSync2 <= rxSync1;
            if (tick) begin
                if (rxSync2 && filtCnt != 2'd3)       filtCnt <= filtCnt + 2'd1;
                else if (!rxSync2 && filtCnt != 2'd0) filtCnt <= filtCnt - 2'd1;
            end
            if (filtCnt == 2'd3)      rxBit <= 1'b1;
            else if (filtCnt == 2'd0) rxBit <= 1'b0;
        end
    end

    assign sample = tick && (phase == PhaseLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            phase           <= '0;
            RxD_data        <= 8'h00;
            RxD_data_ready  <= 1'b0;
            RxD_frame_error <= 1'b0;
        end else begin
            RxD_data_ready  <= 1'b0;
            RxD_frame_error <= 1'b0;
            if (tick) phase <= phase + OsW'(1);
            case (state)
                IDLE: begin
                    // Half-bit preload puts every later sample in the middle of its bit.
                    if (!rxBit) begin
                        state <= START;
                        phase <= PhaseHalf;
                    end
                end
                START: begin
                    if (sample) state <= rxBit ? IDLE : BIT0;
                end
                STOP: begin
                    if (sample) begin
                        if (rxBit) begin
                            RxD_data       <= shiftReg;
                            RxD_data_ready <= 1'b1;
                            state          <= IDLE;
                        end else begin
                            RxD_frame_error <= 1'b1;
                            state           <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rxBit) state <= IDLE;
                end
                default: begin
                    if (state >= BIT0 && state <= BIT7) begin
                        if (sample) state <= state + 4'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // LSB arrives first, so shifting right leaves bit 0 in place after eight samples.
    always_ff @(posedge clk) begin
        if (state >= BIT0 && state <= BIT7 && sample) shiftReg <= {rxBit, shiftReg[7:1]};
    end

`ifdef ASYNC_RECEIVER_IDLE_DETECT_EN
    localparam int GapW = OsW + 5;
    localparam logic [GapW-1:0] GapEop = {{(GapW - 1){1'b1}}, 1'b0};

    logic [GapW-1:0] gapCnt;
    logic [GapW-1:0] gapNext;
    logic            gapInc;

    assign gapNext = gapCnt + GapW'(1);
    assign gapInc  = (state == IDLE) && !RxD_data_ready && tick && !(&gapCnt);

    // Counter saturates at all-ones, so the end-of-packet strobe fires once per gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            gapCnt          <= '0;
            RxD_endofpacket <= 1'b0;
        end else begin
            RxD_endofpacket <= gapInc && (gapNext == GapEop);
            if (state != IDLE || RxD_data_ready) gapCnt <= '0;
            else if (gapInc)                     gapCnt <= gapNext;
        end
    end

    assign RxD_idle = gapCnt[GapW-1];
`endif

endmodule
